// File: rtl/otter_mem_pkg.sv
// Shared types for the OTTER memory arbiter: response owner and access size codes.
package otter_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/otter_mem_arbiter.sv
// Arbitrates the single-ported OTTER memory between instruction fetch and load/store,
// routing each 1-cycle-latency response back to the stage that issued it.
module otter_mem_arbiter
    import otter_mem_pkg::*;
#(
    parameter int unsigned MAX_DM_RUN = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    input  logic        IF_FLUSH,
    output logic        IF_GNT,
    output logic        IF_VALID,
    output logic [31:0] IF_RDATA,
    output logic        IF_ERR,
    input  logic        DM_REQ,
    input  logic        DM_WE,
    input  logic [31:0] DM_ADDR,
    input  logic [31:0] DM_WDATA,
    input  logic [1:0]  DM_SIZE,
    input  logic        DM_SIGN,
    output logic        DM_GNT,
    output logic        DM_VALID,
    output logic [31:0] DM_RDATA,
    output logic        DM_ERR,
    output logic        STALL_IF,
    output logic        STALL_MEM,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic        MEM_RE,
    output logic        MEM_WE,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ERR
);

    localparam logic [3:0] RUN_MAX = 4'(MAX_DM_RUN);

    owner_t      owner_q, owner_d;
    logic [3:0]  run_q, run_d;
    logic        flush_q, flush_d;
    logic        store_q, store_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_err_q, if_err_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        dm_err_q, dm_err_d;
    logic        run_full;
    logic        if_resp;

    // Arbitration, run counter and memory issue
    always_comb begin
        run_full = (run_q == RUN_MAX);
        DM_GNT   = ~RST & DM_REQ & ~(IF_REQ & run_full);
        IF_GNT   = ~RST & IF_REQ & ~DM_GNT;
        STALL_IF  = ~RST & IF_REQ & ~IF_GNT;
        STALL_MEM = ~RST & DM_REQ & ~DM_GNT;

        run_d = run_q;
        if (IF_GNT || !IF_REQ) begin
            run_d = '0;
        end else if (DM_GNT && !run_full) begin
            run_d = run_q + 4'd1;
        end

        owner_d = OWN_NONE;
        if (IF_GNT) begin
            owner_d = OWN_IF;
        end else if (DM_GNT) begin
            owner_d = OWN_DM;
        end
        flush_d = IF_FLUSH;
        store_d = DM_WE;

        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        MEM_SIZE  = '0;
        MEM_SIGN  = 1'b0;
        if (IF_GNT) begin
            MEM_ADDR = IF_ADDR;
            MEM_SIZE = SZ_WORD;
        end else if (DM_GNT) begin
            MEM_ADDR  = DM_ADDR;
            MEM_WDATA = DM_WDATA;
            MEM_SIZE  = DM_SIZE;
            MEM_SIGN  = DM_SIGN;
        end
        MEM_RE = IF_GNT | (DM_GNT & ~DM_WE);
        MEM_WE = DM_GNT & DM_WE;
    end

    // Response routing; data/err fall back to the last delivered value between responses
    always_comb begin
        if_resp  = ~RST & (owner_q == OWN_IF);
        IF_VALID = if_resp & ~flush_q & ~IF_FLUSH;
        DM_VALID = ~RST & (owner_q == OWN_DM);

        if_rdata_d = if_rdata_q;
        if_err_d   = if_err_q;
        dm_rdata_d = dm_rdata_q;
        dm_err_d   = dm_err_q;
        if (RST) begin
            if_rdata_d = '0;
            if_err_d   = 1'b0;
            dm_rdata_d = '0;
            dm_err_d   = 1'b0;
        end else begin
            if (IF_VALID) begin
                if_rdata_d = MEM_RDATA;
                if_err_d   = MEM_ERR;
            end else if (if_resp) begin
                if_rdata_d = '0;
            end
            if (DM_VALID) begin
                dm_rdata_d = store_q ? '0 : MEM_RDATA;
                dm_err_d   = MEM_ERR;
            end
        end
        IF_RDATA = if_rdata_d;
        IF_ERR   = if_err_d;
        DM_RDATA = dm_rdata_d;
        DM_ERR   = dm_err_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            owner_q    <= OWN_NONE;
            run_q      <= '0;
            flush_q    <= 1'b0;
            store_q    <= 1'b0;
            if_rdata_q <= '0;
            if_err_q   <= 1'b0;
            dm_rdata_q <= '0;
            dm_err_q   <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            run_q      <= run_d;
            flush_q    <= flush_d;
            store_q    <= store_d;
            if_rdata_q <= if_rdata_d;
            if_err_q   <= if_err_d;
            dm_rdata_q <= dm_rdata_d;
            dm_err_q   <= dm_err_d;
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Randomized bench for otter_mem_arbiter: a behavioural memory macro plus a request-level
// reference model predicting grants, stalls and routed responses every cycle.
module tb_otter_mem_arbiter;

    localparam int MAX = 4;

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [1:0]  size;
        bit        sign;
    } dm_op_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IF_REQ = 1'b0, IF_FLUSH = 1'b0;
    logic [31:0] IF_ADDR = '0;
    logic        IF_GNT, IF_VALID, IF_ERR;
    logic [31:0] IF_RDATA;
    logic        DM_REQ = 1'b0, DM_WE = 1'b0, DM_SIGN = 1'b0;
    logic [31:0] DM_ADDR = '0, DM_WDATA = '0;
    logic [1:0]  DM_SIZE = '0;
    logic        DM_GNT, DM_VALID, DM_ERR;
    logic [31:0] DM_RDATA;
    logic        STALL_IF, STALL_MEM;
    logic [31:0] MEM_ADDR, MEM_WDATA;
    logic        MEM_RE, MEM_WE, MEM_SIGN;
    logic [1:0]  MEM_SIZE;
    logic [31:0] MEM_RDATA = '0;
    logic        MEM_ERR = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    otter_mem_arbiter #(.MAX_DM_RUN(MAX)) dut (
        .CLK(CLK), .RST(RST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_FLUSH(IF_FLUSH),
        .IF_GNT(IF_GNT), .IF_VALID(IF_VALID), .IF_RDATA(IF_RDATA), .IF_ERR(IF_ERR),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
        .DM_SIZE(DM_SIZE), .DM_SIGN(DM_SIGN),
        .DM_GNT(DM_GNT), .DM_VALID(DM_VALID), .DM_RDATA(DM_RDATA), .DM_ERR(DM_ERR),
        .STALL_IF(STALL_IF), .STALL_MEM(STALL_MEM),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
        .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_RDATA(MEM_RDATA), .MEM_ERR(MEM_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory semantics shared by the macro model and the reference (4 KiB, size-aligned)
    function automatic bit bad_access(input bit [31:0] addr, input bit [1:0] size);
        return (addr >= 32'd4096) || (size == 2'd3) ||
               (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    endfunction

    function automatic bit [31:0] extract(input bit [31:0] word, input bit [31:0] addr,
                                          input bit [1:0] size, input bit sign);
        bit [31:0] sh;
        sh = word >> (8 * addr[1:0]);
        case (size)
            2'd0:    return sign ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
            2'd1:    return sign ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] addr,
                                        input bit [1:0] size, input bit [31:0] wd);
        bit [31:0] mask;
        int sh;
        sh   = 8 * addr[1:0];
        mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        return (old & ~(mask << sh)) | ((wd << sh) & (mask << sh));
    endfunction

    logic [31:0] mem     [0:1023];
    bit   [31:0] ref_mem [0:1023];

    // Memory macro: registered read data and error, one cycle after the access
    always @(posedge CLK) begin
        if (MEM_RE || MEM_WE) begin
            MEM_ERR   <= bad_access(MEM_ADDR, MEM_SIZE);
            MEM_RDATA <= (MEM_RE && !bad_access(MEM_ADDR, MEM_SIZE)) ?
                         extract(mem[MEM_ADDR[11:2]], MEM_ADDR, MEM_SIZE, MEM_SIGN) : 32'd0;
            if (MEM_WE && !bad_access(MEM_ADDR, MEM_SIZE))
                mem[MEM_ADDR[11:2]] <= merge(mem[MEM_ADDR[11:2]], MEM_ADDR, MEM_SIZE, MEM_WDATA);
        end
    end

    bit [31:0] if_q[$];
    dm_op_t    dm_q[$];

    // Reference state: DM wins streak, pending response, last delivered values
    int        run = 0;
    int        resp_kind = 0;
    bit        resp_flush, resp_store, resp_err;
    bit [31:0] resp_data;
    bit [31:0] exp_if_rd = 0, exp_dm_rd = 0;
    bit        exp_if_er = 0, exp_dm_er = 0;
    bit [15:0] dm_trace = 0;

    task automatic cycle(input bit flush, input bit rst);
        bit eif, edm, eiv, edv;
        dm_op_t op;
        if (!IF_REQ && if_q.size() > 0) begin
            IF_REQ  = 1'b1;
            IF_ADDR = if_q.pop_front();
        end
        if (!DM_REQ && dm_q.size() > 0) begin
            op = dm_q.pop_front();
            DM_REQ = 1'b1; DM_WE = op.we; DM_ADDR = op.addr;
            DM_WDATA = op.wdata; DM_SIZE = op.size; DM_SIGN = op.sign;
        end
        IF_FLUSH = flush;
        RST      = rst;
        @(negedge CLK);
        if (rst) begin
            eif = 0; edm = 0; eiv = 0; edv = 0;
            exp_if_rd = 0; exp_if_er = 0; exp_dm_rd = 0; exp_dm_er = 0;
        end else begin
            edm = DM_REQ && !(IF_REQ && run == MAX);
            eif = IF_REQ && !edm;
            eiv = (resp_kind == 1) && !resp_flush && !flush;
            edv = (resp_kind == 2);
            if (resp_kind == 1) begin
                if (eiv) begin
                    exp_if_rd = resp_data;
                    exp_if_er = resp_err;
                end else begin
                    exp_if_rd = 0;
                end
            end
            if (edv) begin
                exp_dm_rd = resp_store ? 32'd0 : resp_data;
                exp_dm_er = resp_err;
            end
        end
        check("if_gnt", IF_GNT, eif);
        check("dm_gnt", DM_GNT, edm);
        check("stall_if", STALL_IF, !rst && IF_REQ && !eif);
        check("stall_mem", STALL_MEM, !rst && DM_REQ && !edm);
        check("if_valid", IF_VALID, eiv);
        check("dm_valid", DM_VALID, edv);
        check("if_rdata", IF_RDATA, exp_if_rd);
        check("if_err", IF_ERR, exp_if_er);
        check("dm_rdata", DM_RDATA, exp_dm_rd);
        check("dm_err", DM_ERR, exp_dm_er);
        if (eif) begin
            check("mem_addr_if", MEM_ADDR, IF_ADDR);
            check("mem_ctl_if", {MEM_RE, MEM_WE, MEM_SIZE, MEM_SIGN}, 5'b10100);
        end else if (edm) begin
            check("mem_addr_dm", MEM_ADDR, DM_ADDR);
            check("mem_ctl_dm", {MEM_RE, MEM_WE, MEM_SIZE, MEM_SIGN},
                  {!DM_WE, DM_WE, DM_SIZE, DM_SIGN});
            if (DM_WE) check("mem_wdata", MEM_WDATA, DM_WDATA);
        end else begin
            check("mem_idle", {MEM_RE, MEM_WE}, 2'b00);
        end
        if (rst) begin
            run = 0;
            resp_kind = 0;
        end else begin
            if (eif || !IF_REQ) run = 0;
            else if (edm && run < MAX) run++;
            resp_kind = eif ? 1 : edm ? 2 : 0;
            if (eif) begin
                resp_flush = flush;
                resp_err   = bad_access(IF_ADDR, 2'd2);
                resp_data  = resp_err ? 32'd0 : ref_mem[IF_ADDR[11:2]];
            end else if (edm) begin
                resp_store = DM_WE;
                resp_err   = bad_access(DM_ADDR, DM_SIZE);
                resp_data  = 0;
                if (!resp_err) begin
                    if (DM_WE)
                        ref_mem[DM_ADDR[11:2]] = merge(ref_mem[DM_ADDR[11:2]], DM_ADDR, DM_SIZE, DM_WDATA);
                    else
                        resp_data = extract(ref_mem[DM_ADDR[11:2]], DM_ADDR, DM_SIZE, DM_SIGN);
                end
            end
        end
        dm_trace = {dm_trace[14:0], edm ? DM_GNT : DM_GNT};
        @(posedge CLK);
        #1;
        if (eif) IF_REQ = 1'b0;
        if (edm) DM_REQ = 1'b0;
    endtask

    function automatic dm_op_t mk_op(input bit we, input bit [31:0] addr, input bit [31:0] wd,
                                     input bit [1:0] size, input bit sign);
        dm_op_t o;
        o.we = we; o.addr = addr; o.wdata = wd; o.size = size; o.sign = sign;
        return o;
    endfunction

    function automatic bit [31:0] rand_addr(input bit [1:0] size);
        bit [31:0] a;
        a = $urandom_range(0, 4095);
        if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << size) - 32'd1);
        if ($urandom_range(0, 15) == 0) a = a + 32'd4096;
        return a;
    endfunction

    initial begin
        bit [1:0] sz;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        cycle(0, 1);
        cycle(0, 1);
        cycle(0, 0);

        // Back-to-back fetches
        if_q.push_back(32'h0); if_q.push_back(32'h4); if_q.push_back(32'h8);
        repeat (5) cycle(0, 0);

        // Simultaneous fetch and load: data side first
        if_q.push_back(32'h10);
        dm_q.push_back(mk_op(0, 32'h100, 0, 2'd2, 0));
        repeat (4) cycle(0, 0);

        // Continuous contention: four DM wins then one forced fetch
        for (int i = 0; i < 12; i++) dm_q.push_back(mk_op(0, 32'h300 + 4 * i, 0, 2'd2, 0));
        for (int i = 0; i < 4; i++) if_q.push_back(32'h80 + 4 * i);
        repeat (10) cycle(0, 0);
        check("run_pattern", {22'd0, dm_trace[9:0]}, 32'b1111011110);
        repeat (8) cycle(0, 0);

        // Store then load the same word
        dm_q.push_back(mk_op(1, 32'h200, 32'hDEADBEEF, 2'd2, 0));
        dm_q.push_back(mk_op(0, 32'h200, 0, 2'd2, 0));
        repeat (4) cycle(0, 0);
        check("store_load", DM_RDATA, 32'hDEADBEEF);

        // Fetch flushed in its response cycle
        if_q.push_back(32'h40);
        cycle(0, 0);
        cycle(1, 0);
        check("flush_rdata", IF_RDATA, 32'h0);
        cycle(0, 0);

        // Reset while a load is in flight
        dm_q.push_back(mk_op(0, 32'h104, 0, 2'd2, 0));
        cycle(0, 0);
        cycle(0, 1);
        cycle(0, 0);
        check("rst_dm_rdata", DM_RDATA, 32'h0);

        for (int i = 0; i < 600; i++) begin
            if (if_q.size() < 2 && $urandom_range(0, 2) != 0)
                if_q.push_back(rand_addr(2'd2));
            if (dm_q.size() < 2 && $urandom_range(0, 1) != 0) begin
                sz = 2'($urandom_range(0, 2));
                dm_q.push_back(mk_op(1'($urandom_range(0, 1)), rand_addr(sz), $urandom, sz,
                                     1'($urandom_range(0, 1))));
            end
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        end
        if_q.delete();
        dm_q.delete();
        repeat (4) cycle(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
